mac_rx_hdr: RTL and testbench
=============================

// Module: mac_rx_hdr
// PURPOSE
//  Ethernet RX header stage directly upstream of the ARP/IPv4 receivers.
//  - Input: a byte stream that starts at the destination MAC, with preamble/SFD/FCS already removed.
//  - Strips the 14-byte MAC header and filters on destination MAC.
//  - Presents the payload bytes with a stable header on the rx_* stream that ARP/IPv4 RX consume.
//  - Keeps saturating accepted/dropped frame counters.
// PARAMETERS
//  PROMISC   0     1: accept any dst MAC; 0: accept only dev_mac or broadcast ff:ff:ff:ff:ff:ff
//  MAX_LEN   1500  max payload bytes; a frame exceeding this is aborted with rx_err
// PORTS
//  clk           in   1   single clock
//  rst           in   1   synchronous, active-high reset
//  dev_mac       in   48  local MAC address (mac_addr_t)
//  in_d          in   8   frame byte
//  in_v          in   1   frame valid; contiguous per frame, >=1 idle cycle between frames
//  in_err        in   1   upstream abort; sampled while in_v=1
//  rx_d          out  8   payload byte
//  rx_v          out  1   payload valid
//  rx_err        out  1   1-cycle abort pulse
//  rx_dst_mac    out  48  header field, stable while rx_v=1 and through rx_done
//  rx_src_mac    out  48  header field, same stability as rx_dst_mac
//  rx_ethertype  out  16  header field, same stability as rx_dst_mac
//  rx_tag        out  16  802.1Q TCI; 0 when the frame is untagged
//  rx_len        out  16  payload byte count; valid on rx_done
//  rx_done       out  1   1-cycle pulse after the last payload byte of an accepted frame
//  cnt_ok        out  16  accepted frames, saturates at 16'hffff
//  cnt_drop      out  16  filtered/runt/errored/oversize frames, saturates at 16'hffff
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE.
//  FSM states: IDLE, HDR, [TAG], PLD, DROP.
//  - IDLE -> HDR only on a rising edge of in_v (in_v=0 the previous cycle).
//  - If in_v is already high when reset releases: IDLE -> DROP. No output, no count.
//  HDR: byte_cnt 0..13 shifts bytes into the header register (big-endian). Fields are
//   latched at byte 13.
//   - Filter is evaluated at byte 5.
//   - On filter miss: -> DROP; cnt_drop++ when the frame ends.
//  PLD: each in_v payload byte is registered to rx_d/rx_v with 1-cycle latency. rx_len counts bytes.
//   - in_v falls: rx_done=1 with final rx_len on the cycle after the last rx_v; cnt_ok++; -> IDLE.
//   - Zero-payload frame (exactly 14 bytes): rx_done with rx_len=0, no rx_v.
//  Runt: in_v falls in HDR -> no rx_v, no rx_done; cnt_drop++; -> IDLE.
//  Error: in_err=1 in PLD, or rx_len would exceed MAX_LEN:
//   - rx_err=1 for 1 cycle and rx_v=0 that cycle.
//   - -> DROP; cnt_drop++ exactly once.
//   - in_err during HDR: -> DROP silently, counted once.
//  DROP: ignore input until in_v=0, then -> IDLE.
//  cnt_ok/cnt_drop: +1 per frame; hold at 16'hffff. A simultaneous cnt_ok and cnt_drop event is impossible (single frame in flight).
//  Reset mid-frame: outputs clear next cycle; the remainder of the frame goes to DROP (rising-edge rule).
// CONFIGURATION
//  ETH_RX_VLAN_EN defined:
//   - ethertype 16'h8100 at bytes 12..13 -> TAG state.
//   - Next 2 bytes -> rx_tag; next 2 bytes -> rx_ethertype.
//   - Payload starts at byte 18.
//   - Runt threshold becomes 18 bytes.
//  ETH_RX_VLAN_EN undefined:
//   - No TAG state; 16'h8100 is passed as rx_ethertype.
//   - Tag bytes are delivered as payload; rx_tag is tied to 0.
// STRUCTURE
//  eth_vlg_pkg: mac_addr_t, mac_hdr_t (dst, src, ethertype, tag, length),
//   MAC_BCAST=48'hffffffffffff, ETH_TYPE_VLAN=16'h8100, ETH_TYPE_ARP=16'h0806, ETH_TYPE_IPV4=16'h0800,
//   mac_rx_fsm_t enum.
//  Single module; the saturating counters are inline (no sub-module).
// TESTING
//  1 Broadcast ARP frame, 14+28 bytes, dst ff..ff, type 0806
//    -> 28 rx_v beats at 1-cycle latency; rx_ethertype=16'h0806; rx_done with rx_len=28; cnt_ok=1.
//  2 Unicast to other MAC 02:00:00:00:00:99, dev_mac=02:00:00:00:00:01, PROMISC=0
//    -> no rx_v/rx_done; cnt_drop=1. Same frame with PROMISC=1 -> accepted.
//  3 in_err on payload byte 5 of a 46-byte payload
//    -> 5 rx_v beats then rx_err 1 cycle; no rx_done; cnt_drop=1; next frame is accepted normally.
//  4 Runt: 10-byte frame -> no output; cnt_drop=1. 1501-byte payload, MAX_LEN=1500
//    -> rx_err after 1500 beats.
//  5 VLAN frame, type 8100, TCI 16'h0064, inner type 0800:
//    - with ETH_RX_VLAN_EN -> rx_tag=16'h0064, rx_ethertype=16'h0800, rx_len = bytes-18.
//    - without -> rx_ethertype=16'h8100, rx_len = bytes-14.
//  6 rst asserted mid-payload, in_v still high -> outputs 0; rest of frame ignored;
//    a back-to-back next frame after a 1-cycle gap is accepted.

Source files
------------

// File: rtl/eth_vlg_pkg.sv
// ----------------------------------------------------------------------------
// eth_vlg_pkg
//   Shared Ethernet types and constants for the MAC receive path.
//   - mac_addr_t   : 48-bit MAC address
//   - mac_hdr_t    : decoded MAC header as presented downstream
//                    (dst, src, ethertype, 802.1Q tag, payload length)
//   - mac_rx_fsm_t : mac_rx_hdr state encoding
//   - sat_inc16    : 16-bit saturating increment used by the frame counters
//   Optional build macro: ETH_RX_VLAN_EN adds the TAG state to mac_rx_fsm_t.
// ----------------------------------------------------------------------------
package eth_vlg_pkg;

    typedef logic [47:0] mac_addr_t;

    typedef struct packed {
        mac_addr_t   dst;
        mac_addr_t   src;
        logic [15:0] ethertype;
        logic [15:0] tag;
        logic [15:0] length;
    } mac_hdr_t;

    localparam mac_addr_t   MAC_BCAST     = 48'hffff_ffff_ffff;
    localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

    // Byte offsets inside the MAC header (byte 0 = first destination byte).
    localparam logic [4:0] HDR_FILTER_BYTE = 5'd5;   // last destination byte
    localparam logic [4:0] HDR_LAST_BYTE   = 5'd13;  // second ethertype byte
    localparam logic [4:0] TAG_TCI_BYTE    = 5'd15;  // second TCI byte
    localparam logic [4:0] TAG_LAST_BYTE   = 5'd17;  // second inner ethertype byte

`ifdef ETH_RX_VLAN_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        TAG  = 3'd2,
        PLD  = 3'd3,
        DROP = 3'd4
    } mac_rx_fsm_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PLD  = 3'd3,
        DROP = 3'd4
    } mac_rx_fsm_t;
`endif

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mac_rx_hdr.sv
// ----------------------------------------------------------------------------
// mac_rx_hdr
//   Ethernet RX header stage in front of the ARP/IPv4 receivers. Takes a byte
//   stream starting at the destination MAC (no preamble/SFD/FCS), strips the
//   14-byte MAC header, filters on destination MAC and forwards the payload
//   with a stable decoded header. Counts accepted and dropped frames.
//
//   Parameters
//     PROMISC  1: accept any destination; 0: only dev_mac or broadcast
//     MAX_LEN  largest payload accepted; one more byte aborts with rx_err
//
//   Ports
//     clk, rst      clock, synchronous active-high reset
//     dev_mac       local MAC address
//     in_d/in_v     frame byte / valid (contiguous per frame, gap between)
//     in_err        upstream abort, sampled while in_v=1
//     rx_d/rx_v     payload byte / valid, one cycle behind the input
//     rx_err        one-cycle abort pulse (rx_v is low in that cycle)
//     rx_dst_mac, rx_src_mac, rx_ethertype, rx_tag
//                   header fields, held from end of header through rx_done
//     rx_len        payload byte count, final value valid with rx_done
//     rx_done       one-cycle pulse after the last payload byte
//     cnt_ok        accepted frames, saturating
//     cnt_drop      filtered/runt/errored/oversize frames, saturating
//
//   Build macro ETH_RX_VLAN_EN: when defined, an 802.1Q tag (type 8100) is
//   decoded into rx_tag and the inner ethertype; payload then starts at byte
//   18. When undefined, the tag bytes are ordinary payload and rx_tag is 0.
// ----------------------------------------------------------------------------
module mac_rx_hdr
    import eth_vlg_pkg::*;
#(
    parameter bit PROMISC = 1'b0,
    parameter int MAX_LEN = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] dev_mac,
    input  logic [7:0]  in_d,
    input  logic        in_v,
    input  logic        in_err,
    output logic [7:0]  rx_d,
    output logic        rx_v,
    output logic        rx_err,
    output logic [47:0] rx_dst_mac,
    output logic [47:0] rx_src_mac,
    output logic [15:0] rx_ethertype,
    output logic [15:0] rx_tag,
    output logic [15:0] rx_len,
    output logic        rx_done,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_drop
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    mac_rx_fsm_t  state_reg;
    logic         in_v_prev_reg;
    logic [4:0]   byte_cnt_reg;
    logic [103:0] hdr_sr_reg;       // last 13 header bytes, newest in [7:0]
    mac_hdr_t     rx_hdr_reg;
    logic [7:0]   rx_d_reg;
    logic         rx_v_reg;
    logic         rx_err_reg;
    logic         rx_done_reg;
    logic [15:0]  cnt_ok_reg;
    logic [15:0]  cnt_drop_reg;
    logic         drop_cnt_pend_reg; // frame in DROP must be counted at its end

    logic         in_rise;
    logic [15:0]  cur_pair;         // previous byte : current byte
    mac_addr_t    dst_now;          // destination as seen on byte 5
    logic         dst_hit;

    // A frame may only start on a rising edge of in_v. in_v_prev_reg resets
    // to 1 so a frame already in progress when reset releases is not taken
    // as a new frame.
    assign in_rise  = in_v & ~in_v_prev_reg;
    assign cur_pair = {hdr_sr_reg[7:0], in_d};
    assign dst_now  = {hdr_sr_reg[39:0], in_d};
    assign dst_hit  = PROMISC || (dst_now == dev_mac) || (dst_now == MAC_BCAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            in_v_prev_reg     <= 1'b1;
            byte_cnt_reg      <= '0;
            hdr_sr_reg        <= '0;
            rx_hdr_reg        <= '0;
            rx_d_reg          <= '0;
            rx_v_reg          <= 1'b0;
            rx_err_reg        <= 1'b0;
            rx_done_reg       <= 1'b0;
            cnt_ok_reg        <= '0;
            cnt_drop_reg      <= '0;
            drop_cnt_pend_reg <= 1'b0;
        end else begin
            in_v_prev_reg <= in_v;
            rx_v_reg      <= 1'b0;
            rx_err_reg    <= 1'b0;
            rx_done_reg   <= 1'b0;

            if (in_v) begin
                hdr_sr_reg <= {hdr_sr_reg[95:0], in_d};
            end

            unique case (state_reg)
                IDLE: begin
                    if (in_rise) begin
                        byte_cnt_reg <= 5'd1;
                        if (in_err) begin
                            state_reg         <= DROP;
                            drop_cnt_pend_reg <= 1'b1;
                        end else begin
                            state_reg <= HDR;
                        end
                    end else if (in_v) begin
                        // Tail of a frame cut by reset: swallow it uncounted.
                        state_reg         <= DROP;
                        drop_cnt_pend_reg <= 1'b0;
                    end
                end

                HDR: begin
                    if (!in_v) begin
                        // Runt: frame ended inside the header.
                        cnt_drop_reg <= sat_inc16(cnt_drop_reg);
                        state_reg    <= IDLE;
                    end else if (in_err) begin
                        state_reg         <= DROP;
                        drop_cnt_pend_reg <= 1'b1;
                    end else begin
                        byte_cnt_reg <= byte_cnt_reg + 5'd1;
                        if (byte_cnt_reg == HDR_FILTER_BYTE && !dst_hit) begin
                            state_reg         <= DROP;
                            drop_cnt_pend_reg <= 1'b1;
                        end else if (byte_cnt_reg == HDR_LAST_BYTE) begin
                            rx_hdr_reg.dst       <= hdr_sr_reg[103:56];
                            rx_hdr_reg.src       <= hdr_sr_reg[55:8];
                            rx_hdr_reg.ethertype <= cur_pair;
                            rx_hdr_reg.tag       <= '0;
                            rx_hdr_reg.length    <= '0;
`ifdef ETH_RX_VLAN_EN
                            state_reg <= (cur_pair == ETH_TYPE_VLAN) ? TAG : PLD;
`else
                            state_reg <= PLD;
`endif
                        end
                    end
                end

`ifdef ETH_RX_VLAN_EN
                TAG: begin
                    if (!in_v) begin
                        // Still a runt: the tagged header is 18 bytes.
                        cnt_drop_reg <= sat_inc16(cnt_drop_reg);
                        state_reg    <= IDLE;
                    end else if (in_err) begin
                        state_reg         <= DROP;
                        drop_cnt_pend_reg <= 1'b1;
                    end else begin
                        byte_cnt_reg <= byte_cnt_reg + 5'd1;
                        if (byte_cnt_reg == TAG_TCI_BYTE) begin
                            rx_hdr_reg.tag <= cur_pair;
                        end
                        if (byte_cnt_reg == TAG_LAST_BYTE) begin
                            rx_hdr_reg.ethertype <= cur_pair;
                            state_reg            <= PLD;
                        end
                    end
                end
`endif

                PLD: begin
                    if (!in_v) begin
                        rx_done_reg <= 1'b1;
                        cnt_ok_reg  <= sat_inc16(cnt_ok_reg);
                        state_reg   <= IDLE;
                    end else if (in_err || rx_hdr_reg.length == MAX_LEN_W) begin
                        // Abort before forwarding the offending byte, so
                        // rx_v stays low in the rx_err cycle.
                        rx_err_reg        <= 1'b1;
                        state_reg         <= DROP;
                        drop_cnt_pend_reg <= 1'b1;
                    end else begin
                        rx_d_reg          <= in_d;
                        rx_v_reg          <= 1'b1;
                        rx_hdr_reg.length <= rx_hdr_reg.length + 16'd1;
                    end
                end

                DROP: begin
                    if (!in_v) begin
                        if (drop_cnt_pend_reg) begin
                            cnt_drop_reg <= sat_inc16(cnt_drop_reg);
                        end
                        drop_cnt_pend_reg <= 1'b0;
                        state_reg         <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rx_d         = rx_d_reg;
    assign rx_v         = rx_v_reg;
    assign rx_err       = rx_err_reg;
    assign rx_done      = rx_done_reg;
    assign rx_dst_mac   = rx_hdr_reg.dst;
    assign rx_src_mac   = rx_hdr_reg.src;
    assign rx_ethertype = rx_hdr_reg.ethertype;
    assign rx_tag       = rx_hdr_reg.tag;
    assign rx_len       = rx_hdr_reg.length;
    assign cnt_ok       = cnt_ok_reg;
    assign cnt_drop     = cnt_drop_reg;

endmodule

// File: tb/tb_mac_rx_hdr.sv
// ----------------------------------------------------------------------------
// tb_mac_rx_hdr
//   Directed bench for mac_rx_hdr. Two instances share the input stream:
//   dut (PROMISC=0) and dut_p (PROMISC=1). Outputs are sampled on the falling
//   edge; inputs are driven on the falling edge.
// ----------------------------------------------------------------------------
module tb_mac_rx_hdr;

    localparam logic [47:0] DEV   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;
    localparam logic [47:0] SRC   = 48'h02_00_00_00_00_55;
    localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;
`ifdef ETH_RX_VLAN_EN
    localparam int VH = 18;
`else
    localparam int VH = 14;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] dev_mac;
    logic [7:0]  in_d;
    logic        in_v;
    logic        in_err;

    logic [7:0]  rx_d, rx_d_p;
    logic        rx_v, rx_v_p, rx_err, rx_err_p, rx_done, rx_done_p;
    logic [47:0] rx_dst_mac, rx_src_mac, rx_dst_mac_p, rx_src_mac_p;
    logic [15:0] rx_ethertype, rx_tag, rx_len, cnt_ok, cnt_drop;
    logic [15:0] rx_ethertype_p, rx_tag_p, rx_len_p, cnt_ok_p, cnt_drop_p;

    mac_rx_hdr #(.PROMISC(1'b0), .MAX_LEN(1500)) dut (
        .clk(clk), .rst(rst), .dev_mac(dev_mac), .in_d(in_d), .in_v(in_v), .in_err(in_err),
        .rx_d(rx_d), .rx_v(rx_v), .rx_err(rx_err), .rx_dst_mac(rx_dst_mac),
        .rx_src_mac(rx_src_mac), .rx_ethertype(rx_ethertype), .rx_tag(rx_tag),
        .rx_len(rx_len), .rx_done(rx_done), .cnt_ok(cnt_ok), .cnt_drop(cnt_drop)
    );

    mac_rx_hdr #(.PROMISC(1'b1), .MAX_LEN(1500)) dut_p (
        .clk(clk), .rst(rst), .dev_mac(dev_mac), .in_d(in_d), .in_v(in_v), .in_err(in_err),
        .rx_d(rx_d_p), .rx_v(rx_v_p), .rx_err(rx_err_p), .rx_dst_mac(rx_dst_mac_p),
        .rx_src_mac(rx_src_mac_p), .rx_ethertype(rx_ethertype_p), .rx_tag(rx_tag_p),
        .rx_len(rx_len_p), .rx_done(rx_done_p), .cnt_ok(cnt_ok_p), .cnt_drop(cnt_drop_p)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: only ever accumulates; the stimulus takes snapshots.
    logic [7:0] rx_buf [0:8191];
    int         rx_cyc [0:8191];
    int beats = 0, errs = 0, dones = 0, overlap = 0, done_cyc = 0;
    int beats_p = 0, dones_p = 0;
    logic [15:0] len_at_done = '0;
    always @(negedge clk) begin
        if (rx_v) begin
            rx_buf[beats % 8192] = rx_d;
            rx_cyc[beats % 8192] = cyc;
            beats++;
        end
        if (rx_err) begin
            errs++;
            if (rx_v) overlap++;
        end
        if (rx_done) begin
            dones++;
            done_cyc    = cyc;
            len_at_done = rx_len;
        end
        if (rx_v_p) beats_p++;
        if (rx_done_p) dones_p++;
    end

    logic [7:0] frame [0:2047];
    int pld_cyc, fall_cyc;
    int b_beats, b_errs, b_dones, b_beats_p, b_dones_p;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        b_beats   = beats;
        b_errs    = errs;
        b_dones   = dones;
        b_beats_p = beats_p;
        b_dones_p = dones_p;
    endtask

    task automatic build(input logic [47:0] dst, input logic [47:0] src,
                         input logic [15:0] et, input int plen);
        for (int i = 0; i < 6; i++) begin
            frame[i]     = dst[47 - 8*i -: 8];
            frame[6 + i] = src[47 - 8*i -: 8];
        end
        frame[12] = et[15:8];
        frame[13] = et[7:0];
        for (int i = 0; i < plen; i++) frame[14 + i] = 8'((i * 37 + plen) & 255);
    endtask

    // Drive n bytes of frame[], in_err on byte err_idx (-1: none), then idle.
    task automatic send(input int n, input int err_idx, input int hdr_len);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_v   = 1'b1;
            in_d   = frame[i];
            in_err = (i == err_idx);
            if (i == hdr_len) pld_cyc = cyc;
        end
        @(negedge clk);
        in_v = 1'b0; in_d = 8'h00; in_err = 1'b0;
        fall_cyc = cyc;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_data(input string tag, input int hdr_len);
        int bad;
        bad = 0;
        for (int i = 0; i < beats - b_beats; i++)
            if (rx_buf[(b_beats + i) % 8192] !== frame[hdr_len + i]) bad++;
        check(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        rst = 1'b1; dev_mac = DEV; in_d = 8'h00; in_v = 1'b0; in_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_v", {63'd0, rx_v}, 64'd0);
        check("reset_rx_done", {63'd0, rx_done}, 64'd0);
        check("reset_rx_len", {48'd0, rx_len}, 64'd0);
        check("reset_dst", {16'd0, rx_dst_mac}, 64'd0);
        check("reset_cnt_ok", {48'd0, cnt_ok}, 64'd0);
        check("reset_cnt_drop", {48'd0, cnt_drop}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: broadcast ARP, 28-byte payload
        build(BCAST, SRC, 16'h0806, 28); mark();
        send(42, -1, 14);
        $display("T1 bcast arp: beats=%0d done=%0d len=%0d", beats - b_beats, dones - b_dones, len_at_done);
        check("t1_beats", 64'(beats - b_beats), 64'd28);
        check_data("t1_data", 14);
        check("t1_latency", 64'(rx_cyc[b_beats % 8192] - pld_cyc), 64'd1);
        check("t1_done", 64'(dones - b_dones), 64'd1);
        check("t1_done_time", 64'(done_cyc - fall_cyc), 64'd1);
        check("t1_len", {48'd0, len_at_done}, 64'd28);
        check("t1_type", {48'd0, rx_ethertype}, 64'h0806);
        check("t1_dst", {16'd0, rx_dst_mac}, {16'd0, BCAST});
        check("t1_src", {16'd0, rx_src_mac}, {16'd0, SRC});
        check("t1_tag", {48'd0, rx_tag}, 64'd0);
        check("t1_cnt_ok", {48'd0, cnt_ok}, 64'd1);

        // 2: unicast to another MAC: filtered, but accepted in promiscuous mode
        build(OTHER, SRC, 16'h0800, 30); mark();
        send(44, -1, 14);
        $display("T2 other mac: beats=%0d done=%0d promisc_done=%0d", beats - b_beats, dones - b_dones, dones_p - b_dones_p);
        check("t2_beats", 64'(beats - b_beats), 64'd0);
        check("t2_done", 64'(dones - b_dones), 64'd0);
        check("t2_cnt_drop", {48'd0, cnt_drop}, 64'd1);
        check("t2_cnt_ok", {48'd0, cnt_ok}, 64'd1);
        check("t2_p_beats", 64'(beats_p - b_beats_p), 64'd30);
        check("t2_p_done", 64'(dones_p - b_dones_p), 64'd1);
        check("t2_p_cnt_ok", {48'd0, cnt_ok_p}, 64'd2);
        check("t2_p_dst", {16'd0, rx_dst_mac_p}, {16'd0, OTHER});

        // unicast to our own MAC
        build(DEV, SRC, 16'h0800, 46); mark();
        send(60, -1, 14);
        $display("T2b own mac: beats=%0d len=%0d", beats - b_beats, len_at_done);
        check("t2b_beats", 64'(beats - b_beats), 64'd46);
        check_data("t2b_data", 14);
        check("t2b_len", {48'd0, len_at_done}, 64'd46);
        check("t2b_cnt_ok", {48'd0, cnt_ok}, 64'd2);

        // 3: in_err on payload byte 5 of a 46-byte payload
        build(DEV, SRC, 16'h0800, 46); mark();
        send(60, 19, 14);
        $display("T3 in_err: beats=%0d err=%0d done=%0d", beats - b_beats, errs - b_errs, dones - b_dones);
        check("t3_beats", 64'(beats - b_beats), 64'd5);
        check_data("t3_data", 14);
        check("t3_err", 64'(errs - b_errs), 64'd1);
        check("t3_err_v_overlap", 64'(overlap), 64'd0);
        check("t3_done", 64'(dones - b_dones), 64'd0);
        check("t3_cnt_drop", {48'd0, cnt_drop}, 64'd2);
        build(BCAST, SRC, 16'h0800, 20); mark();
        send(34, -1, 14);
        $display("T3b next frame: beats=%0d done=%0d", beats - b_beats, dones - b_dones);
        check("t3b_done", 64'(dones - b_dones), 64'd1);
        check("t3b_cnt_ok", {48'd0, cnt_ok}, 64'd3);
        check("t3b_cnt_drop", {48'd0, cnt_drop}, 64'd2);

        // 4: runts, zero payload, oversize, exactly MAX_LEN
        build(BCAST, SRC, 16'h0800, 0); mark();
        send(10, -1, 14);
        send(13, -1, 14);
        $display("T4 runts: beats=%0d done=%0d drop=%0d", beats - b_beats, dones - b_dones, cnt_drop);
        check("t4_runt_beats", 64'(beats - b_beats), 64'd0);
        check("t4_runt_done", 64'(dones - b_dones), 64'd0);
        check("t4_runt_cnt_drop", {48'd0, cnt_drop}, 64'd4);
        mark();
        send(14, -1, 14);
        $display("T4 zero payload: beats=%0d done=%0d len=%0d", beats - b_beats, dones - b_dones, len_at_done);
        check("t4_zero_beats", 64'(beats - b_beats), 64'd0);
        check("t4_zero_done", 64'(dones - b_dones), 64'd1);
        check("t4_zero_len", {48'd0, len_at_done}, 64'd0);
        check("t4_zero_cnt_ok", {48'd0, cnt_ok}, 64'd4);
        build(BCAST, SRC, 16'h0800, 1501); mark();
        send(1515, -1, 14);
        $display("T4 oversize: beats=%0d err=%0d done=%0d", beats - b_beats, errs - b_errs, dones - b_dones);
        check("t4_over_beats", 64'(beats - b_beats), 64'd1500);
        check("t4_over_err", 64'(errs - b_errs), 64'd1);
        check("t4_over_done", 64'(dones - b_dones), 64'd0);
        check("t4_over_cnt_drop", {48'd0, cnt_drop}, 64'd5);
        build(BCAST, SRC, 16'h0800, 1500); mark();
        send(1514, -1, 14);
        $display("T4 max len: beats=%0d done=%0d len=%0d", beats - b_beats, dones - b_dones, len_at_done);
        check("t4_max_done", 64'(dones - b_dones), 64'd1);
        check("t4_max_len", {48'd0, len_at_done}, 64'd1500);
        check("t4_max_err", 64'(errs - b_errs), 64'd0);
        check("t4_max_cnt_ok", {48'd0, cnt_ok}, 64'd5);

        // 5: 802.1Q frame, TCI 0064, inner type 0800, 20 bytes after the tag
        build(DEV, SRC, 16'h8100, 24);
        frame[14] = 8'h00; frame[15] = 8'h64; frame[16] = 8'h08; frame[17] = 8'h00;
        mark();
        send(38, -1, VH);
        $display("T5 vlan: type=%04h tag=%04h len=%0d", rx_ethertype, rx_tag, len_at_done);
`ifdef ETH_RX_VLAN_EN
        check("t5_type", {48'd0, rx_ethertype}, 64'h0800);
        check("t5_tag", {48'd0, rx_tag}, 64'h0064);
        check("t5_len", {48'd0, len_at_done}, 64'd20);
`else
        check("t5_type", {48'd0, rx_ethertype}, 64'h8100);
        check("t5_tag", {48'd0, rx_tag}, 64'h0000);
        check("t5_len", {48'd0, len_at_done}, 64'd24);
`endif
        check_data("t5_data", VH);
        check("t5_cnt_ok", {48'd0, cnt_ok}, 64'd6);

        // 6: reset in the middle of a payload with in_v still high
        build(BCAST, SRC, 16'h0800, 30);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            in_v = 1'b1; in_d = frame[i];
        end
        rst = 1'b1;
        @(negedge clk);
        in_d = frame[24];
        check("t6_rst_rx_v", {63'd0, rx_v}, 64'd0);
        check("t6_rst_len", {48'd0, rx_len}, 64'd0);
        check("t6_rst_cnt_ok", {48'd0, cnt_ok}, 64'd0);
        check("t6_rst_type", {48'd0, rx_ethertype}, 64'd0);
        mark();
        rst = 1'b0;
        for (int i = 25; i < 44; i++) begin
            @(negedge clk);
            in_d = frame[i];
        end
        @(negedge clk);
        in_v = 1'b0;
        build(BCAST, SRC, 16'h0806, 20);
        send(34, -1, 14);
        $display("T6 after reset: beats=%0d done=%0d ok=%0d drop=%0d", beats - b_beats, dones - b_dones, cnt_ok, cnt_drop);
        check("t6_beats", 64'(beats - b_beats), 64'd20);
        check_data("t6_data", 14);
        check("t6_done", 64'(dones - b_dones), 64'd1);
        check("t6_cnt_ok", {48'd0, cnt_ok}, 64'd1);
        check("t6_cnt_drop", {48'd0, cnt_drop}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
